nyakuo_lsu: RTL and testbench

Load/store unit for the nyakuo RV32I core. It sits between the execute stage and the data-memory bus. It consumes the nyakuo_pkg instruction enum for the eight load/store opcodes (LB, LH, LW, LBU, LHU, SB, SH, SW) and issues one word-aligned memory transaction per request. It returns the sign- or zero-extended load data, or a store completion, to writeback.

---
 rtl/nyakuo_lsu.sv | 219 +++++++++++++++++++++
 tb/tb_nyakuo_lsu.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nyakuo_lsu.sv
// nyakuo_lsu: load/store unit for the nyakuo RV32I core.
// It takes one load/store request from execute and issues one word-aligned
// bus transaction. Sub-word stores use byte enables and lane-replicated data.
// Loads are shifted and then sign- or zero-extended before writeback.

package nyakuo_pkg;

    // RV32I instruction set as decoded by the nyakuo front end.
    typedef enum logic [7:0] {
        ILLEGAL = 8'h00,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK
    } instruction;

    function automatic logic op_is_load(input instruction op);
        return op inside {LB, LH, LW, LBU, LHU};
    endfunction

    function automatic logic op_is_store(input instruction op);
        return op inside {SB, SH, SW};
    endfunction

    // Halfword accesses need bit 0 clear and word accesses need bits 1:0 clear.
    // Byte accesses are always aligned.
    function automatic logic op_misaligned(input instruction op, input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        case (op)
            LH, LHU, SH: mis = a[0];
            LW, SW:      mis = |a;
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

module nyakuo_lsu
    import nyakuo_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  instruction        req_op,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB = XLEN / 8;
    // The counter only has to reach TIMEOUT; keep at least one bit so that
    // TIMEOUT=0 (no timeout) still elaborates.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state_reg, state_next;
    instruction        op_reg;
    logic [XLEN-1:0]   addr_reg;
    logic [XLEN-1:0]   wdata_reg;
    logic [4:0]        rd_reg;
    logic [XLEN-1:0]   rdata_reg, rdata_next;
    logic              err_reg, err_next;
    logic [CW-1:0]     cnt_reg, cnt_next;

    logic              accept;
    logic              timeout_hit;
    logic              in_req;
    logic [XLEN-1:0]   load_shifted;
    logic [XLEN-1:0]   load_ext;
    logic [NB-1:0]     be_raw;
    logic [XLEN-1:0]   wdata_raw;

    assign accept      = req_valid && (state_reg == IDLE);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CW'(TIMEOUT));
    assign in_req      = (state_reg == REQ);

    // Request fields are captured once at accept and held for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg    <= ILLEGAL;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rd_reg    <= '0;
        end else if (accept) begin
            op_reg    <= req_op;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            rd_reg    <= req_rd;
        end
    end

    // State, timeout counter and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    // Shift the addressed byte or halfword down to bit 0, then extend it for the opcode.
    always_comb begin
        load_shifted = mem_rdata >> {addr_reg[1:0], 3'b000};
        case (op_reg)
            LB:      load_ext = {{(XLEN-8){load_shifted[7]}}, load_shifted[7:0]};
            LBU:     load_ext = {{(XLEN-8){1'b0}}, load_shifted[7:0]};
            LH:      load_ext = {{(XLEN-16){load_shifted[15]}}, load_shifted[15:0]};
            LHU:     load_ext = {{(XLEN-16){1'b0}}, load_shifted[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    // Next-state logic. A timeout takes priority over a late gnt or rvalid.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    rdata_next = '0;
                    cnt_next   = '0;
                    if (!(op_is_load(req_op) || op_is_store(req_op)) ||
                        op_misaligned(req_op, req_addr[1:0])) begin
                        err_next   = 1'b1;
                        state_next = RESP;
                    end else begin
                        err_next   = 1'b0;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (timeout_hit) begin
                    err_next   = 1'b1;
                    rdata_next = '0;
                    state_next = RESP;
                end else if (mem_gnt) begin
                    cnt_next   = '0;
                    state_next = op_is_store(op_reg) ? RESP : WAIT;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            WAIT: begin
                if (timeout_hit) begin
                    err_next   = 1'b1;
                    rdata_next = '0;
                    state_next = RESP;
                end else if (mem_rvalid) begin
                    rdata_next = load_ext;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-lane byte enable and store data. SB drives one lane and SH drives
    // one halfword. All other ops, including every load, enable the full word.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign be_raw[gi] = (op_reg == SB) ? (addr_reg[1:0] == 2'(gi)) :
                            (op_reg == SH) ? (addr_reg[1] == 1'(gi / 2)) :
                                             1'b1;
        assign wdata_raw[8*gi +: 8] = (op_reg == SB) ? wdata_reg[7:0] :
                                      (op_reg == SH) ? wdata_reg[8*(gi % 2) +: 8] :
                                                       wdata_reg[8*gi +: 8];
    end

    // The bus signals are held steady for all of REQ and are zero everywhere else.
    assign mem_req   = in_req && !timeout_hit;
    assign mem_we    = in_req && op_is_store(op_reg);
    assign mem_addr  = in_req ? {addr_reg[XLEN-1:2], 2'b00} : '0;
    assign mem_be    = in_req ? be_raw : '0;
    assign mem_wdata = in_req ? wdata_raw : '0;

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = resp_valid ? rdata_reg : '0;
    assign resp_err   = resp_valid && err_reg;
    assign resp_rd    = rd_reg;

endmodule

// File: tb/tb_nyakuo_lsu.sv
// Directed testbench for nyakuo_lsu, built with TIMEOUT=4.
// A small bus model grants after gnt_delay request cycles, or never when gnt_never is set.
// It returns rvalid one cycle after a granted read unless rv_hold is set.
module tb_nyakuo_lsu;
    import nyakuo_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    instruction  req_op = ILLEGAL;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int          checks = 0;
    int          failures = 0;

    int          gnt_delay = 0;
    logic        gnt_never = 1'b0;
    logic        rv_hold = 1'b0;
    logic [31:0] mem_word = '0;
    int          gnt_cnt = 0;
    logic        rv_pend = 1'b0;

    always #5 clk = ~clk;

    nyakuo_lsu #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
        .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    // Bus model.
    assign mem_gnt    = mem_req && !gnt_never && (gnt_cnt >= gnt_delay);
    assign mem_rvalid = rv_pend && !rv_hold;
    assign mem_rdata  = mem_rvalid ? mem_word : 32'h0;

    always_ff @(posedge clk) begin
        gnt_cnt <= (mem_req && !mem_gnt) ? gnt_cnt + 1 : 0;
        if (mem_req && mem_gnt && !mem_we)
            rv_pend <= 1'b1;
        else if (mem_rvalid)
            rv_pend <= 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Results of the most recent transaction.
    int          t_lat;
    int          t_reqs;
    logic        t_stable;
    logic        t_err;
    logic        t_after;
    logic [31:0] t_rdata;
    logic [4:0]  t_rd;
    logic [31:0] t_addr;
    logic [3:0]  t_be;
    logic [31:0] t_wdata;
    logic        t_we;

    // Issue one request, then watch it until the response or until the cycle budget runs out.
    // t_lat counts cycles after the accept edge. It is -1 if no response arrives.
    task automatic txn(input instruction op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
        logic seen;
        seen = 1'b0;
        t_lat = -1; t_reqs = 0; t_stable = 1'b1; t_err = 1'b0; t_after = 1'b0;
        t_rdata = '0; t_rd = '0; t_addr = '0; t_be = '0; t_wdata = '0; t_we = 1'b0;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mem_req) begin
                if (!seen) begin
                    seen = 1'b1;
                    t_addr = mem_addr; t_be = mem_be; t_wdata = mem_wdata; t_we = mem_we;
                end else if (mem_addr !== t_addr || mem_be !== t_be ||
                             mem_wdata !== t_wdata || mem_we !== t_we) begin
                    t_stable = 1'b0;
                end
                t_reqs++;
            end
            if (resp_valid) begin
                t_lat = k; t_rdata = resp_rdata; t_err = resp_err; t_rd = resp_rd;
                break;
            end
        end
        @(negedge clk);
        t_after = resp_valid;
        $display("txn %s addr=%h wdata=%h lat=%0d rdata=%h err=%0d rd=%0d be=%b we=%0d reqs=%0d",
                 op.name(), addr, wdata, t_lat, t_rdata, t_err, t_rd, t_be, t_we, t_reqs);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        rst = 1'b0;

        // LW, aligned, with immediate gnt and rvalid.
        mem_word = 32'hDEADBEEF;
        txn(LW, 32'h100, 32'h0, 5'd5);
        chk("lw_lat", 32'(t_lat), 32'd3);
        chk("lw_rdata", t_rdata, 32'hDEADBEEF);
        chk("lw_err", 32'(t_err), 32'd0);
        chk("lw_addr", t_addr, 32'h100);
        chk("lw_be", 32'(t_be), 32'hF);
        chk("lw_we", 32'(t_we), 32'd0);
        chk("lw_rd", 32'(t_rd), 32'd5);
        chk("lw_one_pulse", 32'(t_after), 32'd0);

        // Byte and halfword extraction from 0x80112233.
        mem_word = 32'h80112233;
        txn(LB, 32'h103, 32'h0, 5'd6);
        chk("lb_rdata", t_rdata, 32'hFFFFFF80);
        chk("lb_addr", t_addr, 32'h100);
        txn(LBU, 32'h103, 32'h0, 5'd7);
        chk("lbu_rdata", t_rdata, 32'h00000080);
        txn(LH, 32'h102, 32'h0, 5'd8);
        chk("lh_rdata", t_rdata, 32'hFFFF8011);
        txn(LHU, 32'h102, 32'h0, 5'd9);
        chk("lhu_rdata", t_rdata, 32'h00008011);
        txn(LB, 32'h101, 32'h0, 5'd9);
        chk("lb1_rdata", t_rdata, 32'h00000022);

        // Stores.
        txn(SH, 32'h202, 32'h0000ABCD, 5'd10);
        chk("sh_lat", 32'(t_lat), 32'd2);
        chk("sh_addr", t_addr, 32'h200);
        chk("sh_be", 32'(t_be), 32'hC);
        chk("sh_wdata", t_wdata, 32'hABCDABCD);
        chk("sh_we", 32'(t_we), 32'd1);
        chk("sh_rdata", t_rdata, 32'd0);
        chk("sh_err", 32'(t_err), 32'd0);
        txn(SB, 32'h101, 32'h0000005A, 5'd11);
        chk("sb_be", 32'(t_be), 32'h2);
        chk("sb_wdata", t_wdata, 32'h5A5A5A5A);

        // Misaligned accesses and non-LS opcodes: no bus activity, immediate error.
        txn(LW, 32'h101, 32'h0, 5'd12);
        chk("lw_mis_lat", 32'(t_lat), 32'd1);
        chk("lw_mis_err", 32'(t_err), 32'd1);
        chk("lw_mis_reqs", 32'(t_reqs), 32'd0);
        chk("lw_mis_rdata", t_rdata, 32'd0);
        chk("lw_mis_rd", 32'(t_rd), 32'd12);
        txn(SH, 32'h003, 32'h1234, 5'd13);
        chk("sh_mis_lat", 32'(t_lat), 32'd1);
        chk("sh_mis_err", 32'(t_err), 32'd1);
        chk("sh_mis_reqs", 32'(t_reqs), 32'd0);
        txn(ADD, 32'h100, 32'h0, 5'd14);
        chk("add_err", 32'(t_err), 32'd1);
        chk("add_reqs", 32'(t_reqs), 32'd0);

        // SW with gnt held low for 3 cycles: the request is held for 4 cycles.
        gnt_delay = 3;
        txn(SW, 32'h300, 32'h12345678, 5'd15);
        chk("sw_wait_reqs", 32'(t_reqs), 32'd4);
        chk("sw_wait_stable", 32'(t_stable), 32'd1);
        chk("sw_wait_lat", 32'(t_lat), 32'd5);
        chk("sw_wait_wdata", t_wdata, 32'h12345678);
        chk("sw_wait_be", 32'(t_be), 32'hF);
        chk("sw_wait_err", 32'(t_err), 32'd0);
        gnt_delay = 0;

        // gnt never arrives. With TIMEOUT=4 there are 4 request cycles,
        // then one cycle with mem_req low, then the error response.
        gnt_never = 1'b1;
        txn(SW, 32'h304, 32'hCAFEF00D, 5'd16);
        chk("to_err", 32'(t_err), 32'd1);
        chk("to_reqs", 32'(t_reqs), 32'd4);
        chk("to_lat", 32'(t_lat), 32'd6);
        chk("to_rdata", t_rdata, 32'd0);
        chk("to_rd", 32'(t_rd), 32'd16);
        chk("to_mem_req_low", 32'(mem_req), 32'd0);
        gnt_never = 1'b0;

        // Reset during WAIT. The late rvalid is ignored and no response is produced.
        rv_hold = 1'b1;
        mem_word = 32'h55AA55AA;
        @(negedge clk);
        req_valid = 1'b1; req_op = LW; req_addr = 32'h400; req_rd = 5'd17;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);                   // T+1: REQ, granted
        @(negedge clk);                   // T+2: WAIT, rvalid held off
        chk("rstw_ready_busy", 32'(req_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rv_hold = 1'b0;                   // rvalid now arrives late
        chk("rstw_ready", 32'(req_ready), 32'd1);
        chk("rstw_resp", 32'(resp_valid), 32'd0);
        begin
            logic any_resp;
            any_resp = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                any_resp = any_resp | resp_valid;
            end
            chk("rstw_no_resp", 32'(any_resp), 32'd0);
        end
        $display("txn RESET_IN_WAIT addr=00000400 late rvalid ignored");

        // The LSU still works normally after the abort.
        mem_word = 32'h0BADF00D;
        txn(LW, 32'h104, 32'h0, 5'd18);
        chk("post_lat", 32'(t_lat), 32'd3);
        chk("post_rdata", t_rdata, 32'h0BADF00D);
        chk("post_rd", 32'(t_rd), 32'd18);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
